// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/OVF FSM driving a min:sec:ms cascade; all state moves on the falling clock edge.
// Defining STOPWATCH_LAP_EN adds the lap capture handshake (lap_req/lap_ack/lap_valid and lap value registers).
module stopwatch_ctrl #(
    parameter int MS_MAX  = 999,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap_req,
    input  logic       lap_ack,
    output logic       lap_valid,
    output logic [9:0] lap_ms,
    output logic [5:0] lap_sec,
    output logic [5:0] lap_min,
`endif
    output logic       running,
    output logic       overflow,
    output logic [9:0] ms_cnt,
    output logic [5:0] sec_cnt,
    output logic [5:0] min_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } state_t;

    localparam logic [9:0] MS_TOP  = 10'(MS_MAX);
    localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);
    localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);

    state_t     state_q, state_d;
    logic [9:0] ms_q, ms_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;

    logic count_en;
    logic ms_wrap;
    logic sec_wrap;
    logic at_max;

    // A tick counts in every RUN edge not overridden by clear, including the stop edge;
    // the edge entering RUN starts from IDLE/PAUSE, so it never counts.
    assign count_en = (state_q == RUN) && ms_tick && !clear;
    assign ms_wrap  = (ms_q == MS_TOP);
    assign sec_wrap = (sec_q == SEC_TOP);
    assign at_max   = ms_wrap && sec_wrap && (min_q == MIN_TOP);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ms_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start) begin
            if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
        end
        if (count_en && at_max) state_d = OVF;
    end

    always_comb begin
        ms_d  = ms_q;
        sec_d = sec_q;
        min_d = min_q;
        if (clear) begin
            ms_d  = '0;
            sec_d = '0;
            min_d = '0;
        end else if (count_en && !at_max) begin
            if (ms_wrap) begin
                ms_d = '0;
                if (sec_wrap) begin
                    sec_d = '0;
                    min_d = min_q + 6'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                ms_d = ms_q + 10'd1;
            end
        end
    end

    always_comb begin
        running  = (state_q == RUN);
        overflow = (state_q == OVF);
    end

    assign ms_cnt  = ms_q;
    assign sec_cnt = sec_q;
    assign min_cnt = min_q;

`ifdef STOPWATCH_LAP_EN
    logic       lap_valid_q, lap_valid_d;
    logic [9:0] lap_ms_q, lap_ms_d;
    logic [5:0] lap_sec_q, lap_sec_d;
    logic [5:0] lap_min_q, lap_min_d;
    logic       lap_cap;

    // An ack on the same edge frees the slot, so a coincident request recaptures.
    assign lap_cap = lap_req && (state_q == RUN || state_q == PAUSE) && (!lap_valid_q || lap_ack);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            lap_valid_q <= 1'b0;
            lap_ms_q    <= '0;
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
        end else begin
            lap_valid_q <= lap_valid_d;
            lap_ms_q    <= lap_ms_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
        end
    end

    always_comb begin
        lap_valid_d = lap_valid_q;
        lap_ms_d    = lap_ms_q;
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        if (clear) begin
            lap_valid_d = 1'b0;
            lap_ms_d    = '0;
            lap_sec_d   = '0;
            lap_min_d   = '0;
        end else if (lap_cap) begin
            lap_valid_d = 1'b1;
            lap_ms_d    = ms_q;
            lap_sec_d   = sec_q;
            lap_min_d   = min_q;
        end else if (lap_ack) begin
            lap_valid_d = 1'b0;
        end
    end

    assign lap_valid = lap_valid_q;
    assign lap_ms    = lap_ms_q;
    assign lap_sec   = lap_sec_q;
    assign lap_min   = lap_min_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a default-size instance and a small instance (9 ms, 5 s, 3 min) share stimulus,
// each tracked by an elapsed-milliseconds reference model; lap checks compile in with STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVF   = 3;

    logic clk = 1'b1;
    logic rst = 1'b1;
    logic ms_tick = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;

    logic       big_running, big_overflow, sm_running, sm_overflow;
    logic [9:0] big_ms, sm_ms;
    logic [5:0] big_sec, big_min, sm_sec, sm_min;
    logic [23:0] big_obs, sm_obs;

    int checks = 0;
    int errors = 0;

    int m_mode[2];
    int m_total[2];

    assign big_obs = {big_running, big_overflow, big_ms, big_sec, big_min};
    assign sm_obs  = {sm_running, sm_overflow, sm_ms, sm_sec, sm_min};

`ifdef STOPWATCH_LAP_EN
    logic lap_req = 1'b0;
    logic lap_ack = 1'b0;
    logic       big_lv, sm_lv;
    logic [9:0] big_lms, sm_lms;
    logic [5:0] big_lsec, big_lmin, sm_lsec, sm_lmin;
    logic [22:0] big_lap, sm_lap;
    int m_lv[2], m_lms[2], m_lsec[2], m_lmin[2];
    assign big_lap = {big_lv, big_lms, big_lsec, big_lmin};
    assign sm_lap  = {sm_lv, sm_lms, sm_lsec, sm_lmin};
`endif

    stopwatch_ctrl u_big (
        .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap_req(lap_req), .lap_ack(lap_ack), .lap_valid(big_lv),
        .lap_ms(big_lms), .lap_sec(big_lsec), .lap_min(big_lmin),
`endif
        .running(big_running), .overflow(big_overflow),
        .ms_cnt(big_ms), .sec_cnt(big_sec), .min_cnt(big_min)
    );

    stopwatch_ctrl #(.MS_MAX(9), .SEC_MAX(5), .MIN_MAX(3)) u_small (
        .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start), .stop(stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap_req(lap_req), .lap_ack(lap_ack), .lap_valid(sm_lv),
        .lap_ms(sm_lms), .lap_sec(sm_lsec), .lap_min(sm_lmin),
`endif
        .running(sm_running), .overflow(sm_overflow),
        .ms_cnt(sm_ms), .sec_cnt(sm_sec), .min_cnt(sm_min)
    );

    always #5 clk = ~clk;

    // Field spans (max+1) of each instance; the model keeps only total elapsed ms.
    function automatic int span_ms(int d);
        return (d == 0) ? 1000 : 10;
    endfunction
    function automatic int span_sec(int d);
        return (d == 0) ? 60 : 6;
    endfunction
    function automatic int span_min(int d);
        return (d == 0) ? 60 : 4;
    endfunction
    function automatic int e_ms(int d);
        return m_total[d] % span_ms(d);
    endfunction
    function automatic int e_sec(int d);
        return (m_total[d] / span_ms(d)) % span_sec(d);
    endfunction
    function automatic int e_min(int d);
        return m_total[d] / (span_ms(d) * span_sec(d));
    endfunction

    function automatic logic [23:0] pk(int r, int o, int ms, int s, int m);
        return {r[0], o[0], ms[9:0], s[5:0], m[5:0]};
    endfunction

    function automatic logic [23:0] exp_obs(int d);
        return pk(int'(m_mode[d] == M_RUN), int'(m_mode[d] == M_OVF), e_ms(d), e_sec(d), e_min(d));
    endfunction

`ifdef STOPWATCH_LAP_EN
    function automatic logic [22:0] exp_lap(int d);
        return {1'(m_lv[d]), 10'(m_lms[d]), 6'(m_lsec[d]), 6'(m_lmin[d])};
    endfunction
`endif

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d]  = M_IDLE;
            m_total[d] = 0;
`ifdef STOPWATCH_LAP_EN
            m_lv[d] = 0; m_lms[d] = 0; m_lsec[d] = 0; m_lmin[d] = 0;
`endif
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int cur;
            int nxt;
            cur = m_mode[d];
            nxt = cur;
`ifdef STOPWATCH_LAP_EN
            if (clear) begin
                m_lv[d] = 0; m_lms[d] = 0; m_lsec[d] = 0; m_lmin[d] = 0;
            end else if (lap_req && (cur == M_RUN || cur == M_PAUSE) && (m_lv[d] == 0 || lap_ack)) begin
                m_lv[d] = 1; m_lms[d] = e_ms(d); m_lsec[d] = e_sec(d); m_lmin[d] = e_min(d);
            end else if (lap_ack) begin
                m_lv[d] = 0;
            end
`endif
            if (clear) begin
                nxt = M_IDLE;
                m_total[d] = 0;
            end else begin
                if (stop) begin
                    if (cur == M_RUN) nxt = M_PAUSE;
                end else if (start) begin
                    if (cur == M_IDLE || cur == M_PAUSE) nxt = M_RUN;
                end
                if (cur == M_RUN && ms_tick) begin
                    if (m_total[d] == span_ms(d) * span_sec(d) * span_min(d) - 1) nxt = M_OVF;
                    else m_total[d] = m_total[d] + 1;
                end
            end
            m_mode[d] = nxt;
        end
    endtask

    // One falling edge with the given commands; lap inputs are set by the caller and released here.
    task automatic cyc(input logic t, input logic s, input logic p, input logic c);
        ms_tick = t; start = s; stop = p; clear = c;
        @(negedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        ms_tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_req = 1'b0; lap_ack = 1'b0;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (big_obs !== 24'h0) begin
            errors++; $display("FAIL reset_big got %h exp %h", big_obs, 24'h0);
        end
        checks++;
        if (sm_obs !== 24'h0) begin
            errors++; $display("FAIL reset_small got %h exp %h", sm_obs, 24'h0);
        end
`ifdef STOPWATCH_LAP_EN
        checks++;
        if (big_lap !== 23'h0) begin
            errors++; $display("FAIL reset_lap got %h exp %h", big_lap, 23'h0);
        end
`endif
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (big_obs !== 24'h0) begin
            errors++; $display("FAIL reset_no_autostart got %h exp %h", big_obs, 24'h0);
        end
        $display("test_reset done");
    endtask

    task automatic test_count();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (big_obs !== pk(1, 0, 0, 0, 0)) begin
            errors++; $display("FAIL enter_run_tick got %h exp %h", big_obs, pk(1, 0, 0, 0, 0));
        end
        ticks(1500);
        checks++;
        if (big_obs !== pk(1, 0, 500, 1, 0)) begin
            errors++; $display("FAIL count_1500 got %h exp %h", big_obs, pk(1, 0, 500, 1, 0));
        end
        $display("test_count done");
    endtask

    task automatic test_cascade();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(59);
        checks++;
        if (sm_obs !== pk(1, 0, 9, 5, 0)) begin
            errors++; $display("FAIL cascade_pre got %h exp %h", sm_obs, pk(1, 0, 9, 5, 0));
        end
        ticks(1);
        checks++;
        if (sm_obs !== pk(1, 0, 0, 0, 1)) begin
            errors++; $display("FAIL cascade_wrap got %h exp %h", sm_obs, pk(1, 0, 0, 0, 1));
        end
        $display("test_cascade done");
    endtask

    task automatic test_stop_tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (big_obs !== pk(0, 0, 11, 0, 0)) begin
            errors++; $display("FAIL stop_edge_tick got %h exp %h", big_obs, pk(0, 0, 11, 0, 0));
        end
        ticks(5);
        checks++;
        if (big_obs !== pk(0, 0, 11, 0, 0)) begin
            errors++; $display("FAIL pause_hold got %h exp %h", big_obs, pk(0, 0, 11, 0, 0));
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (big_obs !== pk(1, 0, 11, 0, 0)) begin
            errors++; $display("FAIL resume got %h exp %h", big_obs, pk(1, 0, 11, 0, 0));
        end
        $display("test_stop_tick done");
    endtask

    task automatic test_overflow();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(239);
        checks++;
        if (sm_obs !== pk(1, 0, 9, 5, 3)) begin
            errors++; $display("FAIL ovf_pre got %h exp %h", sm_obs, pk(1, 0, 9, 5, 3));
        end
        ticks(1);
        checks++;
        if (sm_obs !== pk(0, 1, 9, 5, 3)) begin
            errors++; $display("FAIL ovf_enter got %h exp %h", sm_obs, pk(0, 1, 9, 5, 3));
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (sm_obs !== pk(0, 1, 9, 5, 3)) begin
            errors++; $display("FAIL ovf_sticky got %h exp %h", sm_obs, pk(0, 1, 9, 5, 3));
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sm_obs !== 24'h0) begin
            errors++; $display("FAIL ovf_clear got %h exp %h", sm_obs, 24'h0);
        end
        $display("test_overflow done");
    endtask

    task automatic test_priority_rst();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (big_obs !== 24'h0) begin
            errors++; $display("FAIL all_cmds got %h exp %h", big_obs, 24'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(777);
        checks++;
        if (big_obs !== pk(1, 0, 777, 0, 0)) begin
            errors++; $display("FAIL pre_rst got %h exp %h", big_obs, pk(1, 0, 777, 0, 0));
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (big_obs !== 24'h0) begin
            errors++; $display("FAIL async_rst got %h exp %h", big_obs, 24'h0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (big_obs !== 24'h0) begin
            errors++; $display("FAIL rst_ignores got %h exp %h", big_obs, 24'h0);
        end
        rst = 1'b0;
        ticks(3);
        checks++;
        if (big_obs !== 24'h0) begin
            errors++; $display("FAIL rst_needs_start got %h exp %h", big_obs, 24'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        checks++;
        if (big_obs !== pk(1, 0, 3, 0, 0)) begin
            errors++; $display("FAIL post_rst_count got %h exp %h", big_obs, pk(1, 0, 3, 0, 0));
        end
        $display("test_priority_rst done");
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2345);
        lap_req = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (big_lap !== {1'b1, 10'd345, 6'd2, 6'd0}) begin
            errors++; $display("FAIL lap_capture got %h exp %h", big_lap, {1'b1, 10'd345, 6'd2, 6'd0});
        end
        ticks(3);
        lap_req = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (big_lap !== {1'b1, 10'd345, 6'd2, 6'd0}) begin
            errors++; $display("FAIL lap_hold got %h exp %h", big_lap, {1'b1, 10'd345, 6'd2, 6'd0});
        end
        lap_ack = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (big_lv !== 1'b0) begin
            errors++; $display("FAIL lap_ack got %b exp %b", big_lv, 1'b0);
        end
        lap_req = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        lap_req = 1'b1; lap_ack = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (big_lap !== {1'b1, 10'd352, 6'd2, 6'd0}) begin
            errors++; $display("FAIL lap_req_ack got %h exp %h", big_lap, {1'b1, 10'd352, 6'd2, 6'd0});
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (big_lap !== 23'h0) begin
            errors++; $display("FAIL lap_clear got %h exp %h", big_lap, 23'h0);
        end
        $display("test_lap done");
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
`ifdef STOPWATCH_LAP_EN
            lap_req = ($urandom_range(99) < 6);
            lap_ack = ($urandom_range(99) < 10);
`endif
            cyc($urandom_range(99) < 75, $urandom_range(99) < 5,
                $urandom_range(99) < 3, $urandom_range(999) < 3);
            checks++;
            if (big_obs !== exp_obs(0)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_big cyc %0d got %h exp %h", i, big_obs, exp_obs(0));
            end
            checks++;
            if (sm_obs !== exp_obs(1)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_small cyc %0d got %h exp %h", i, sm_obs, exp_obs(1));
            end
`ifdef STOPWATCH_LAP_EN
            checks++;
            if (big_lap !== exp_lap(0) || sm_lap !== exp_lap(1)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_lap cyc %0d got %h/%h exp %h/%h",
                                       i, big_lap, sm_lap, exp_lap(0), exp_lap(1));
            end
`endif
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_count();
        test_cascade();
        test_stop_tick();
        test_overflow();
        test_priority_rst();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
